// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF stage: butterfly mode decode,
// twiddle address generation, and delay-line drain/chaining at frame boundaries.
//
// state | meaning
// IDLE  | no frame in progress, waiting for the first sample
// PRIME | filling the delay line with the first DELAY samples of a fresh frame
// RUN   | butterfly/twiddle phase; frame-end decision happens here via end_pend
// DRAIN | flushing the delay line for DELAY cycles, input stalled
module sdf_stage_ctrl #(
    parameter int FRAME_LEN = 128,
    parameter int DELAY     = 8,
    parameter int TW_STEP   = 8,
    parameter int TW_AW     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       mode,
    output logic [TW_AW-1:0] tw_addr,
    output logic             tw_en,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int HB = $clog2(DELAY);
    localparam int DW = (DELAY > 1) ? HB : 1;
    localparam int SH = $clog2(TW_STEP);

    localparam logic [1:0]    M_FILL    = 2'd0;
    localparam logic [1:0]    M_BFLY    = 2'd1;
    localparam logic [1:0]    M_TWID    = 2'd2;
    localparam logic [PW-1:0] POS_JMASK = PW'(DELAY - 1);
    localparam logic [PW-1:0] POS_PEND  = PW'(DELAY - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DELAY - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pos, pos_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic            chained, chained_nxt;
    logic            end_pend, end_pend_nxt;
    logic            acc, h, drain_now;
    logic [PW-1:0]   j;
    logic [TW_AW-1:0] run_addr, drain_addr;

    // h never reaches past pos because DELAY <= FRAME_LEN/2
    assign h          = pos[HB];
    assign j          = pos & POS_JMASK;
    assign run_addr   = TW_AW'(j) << SH;
    assign drain_addr = TW_AW'(dcnt) << SH;

    // The first cycle after frame end without a new sample is already drain cycle 0
    assign drain_now = (state == DRAIN) || ((state == RUN) && end_pend && !in_valid);
    assign in_ready  = !drain_now;
    assign acc       = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos      <= '0;
            dcnt     <= '0;
            chained  <= 1'b0;
            end_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            dcnt     <= dcnt_nxt;
            chained  <= chained_nxt;
            end_pend <= end_pend_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        dcnt_nxt     = dcnt;
        chained_nxt  = chained;
        end_pend_nxt = end_pend;
        mode         = M_FILL;
        tw_addr      = '0;
        tw_en        = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                if (acc) begin
                    state_nxt = (DELAY == 1) ? RUN : PRIME;
                    pos_nxt   = PW'(1);
                end
            end
            PRIME: begin
                if (acc) begin
                    pos_nxt = pos + PW'(1);
                    if (pos == POS_PEND) state_nxt = RUN;
                end
            end
            RUN: begin
                if (drain_now) begin
                    mode         = M_TWID;
                    tw_en        = 1'b1;
                    tw_addr      = drain_addr;
                    out_valid    = 1'b1;
                    end_pend_nxt = 1'b0;
                    if (DELAY == 1) begin
                        out_last  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DRAIN;
                        dcnt_nxt  = dcnt + DW'(1);
                    end
                end else begin
                    mode = h ? M_BFLY : M_TWID;
                    if (acc) begin
                        out_valid = 1'b1;
                        tw_en     = !h;
                        tw_addr   = h ? '0 : run_addr;
                        pos_nxt   = pos + PW'(1);
                        if (end_pend) begin
                            end_pend_nxt = 1'b0;
                            chained_nxt  = 1'b1;
                        end
                        // Tail of the previous frame finishes at pos DELAY-1
                        if (chained && (pos == POS_PEND)) begin
                            out_last    = 1'b1;
                            chained_nxt = 1'b0;
                        end
                        if (pos == POS_LAST) end_pend_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                mode      = M_TWID;
                tw_en     = 1'b1;
                tw_addr   = drain_addr;
                out_valid = 1'b1;
                dcnt_nxt  = dcnt + DW'(1);
                if (dcnt == DCNT_LAST) begin
                    out_last  = 1'b1;
                    state_nxt = IDLE;
                    pos_nxt   = '0;
                    dcnt_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: two instances (DELAY=8 and DELAY=4) share one
// input stream and are checked every cycle against a frame-counting model.
module tb_sdf_stage_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       o_rdy  [2];
    logic [1:0] o_md   [2];
    logic [5:0] o_ad   [2];
    logic       o_en   [2];
    logic       o_ov   [2];
    logic       o_ls   [2];
    logic       o_bsy  [2];

    int n_vec = 0;
    int n_bad = 0;

    // model state: samples taken in current frame, frame active, frame chained,
    // frame-end decision pending, drain cycles left
    int DL [2] = '{8, 4};
    int STP[2] = '{8, 16};
    localparam int FL = 128;
    int m_n [2];
    bit m_act[2], m_chf[2], m_pend[2];
    int m_dl [2];

    bit rec_on = 1'b0;
    int rec_c = 0;
    int rec_md[2][160], rec_ad[2][160], rec_en[2][160], rec_ls[2][160];
    int rec_bsy[2][160], rec_rdy[2][160], rec_ov[2][160];

    always #5 clk = ~clk;

    sdf_stage_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .mode(o_md[0]), .tw_addr(o_ad[0]), .tw_en(o_en[0]), .out_valid(o_ov[0]),
        .out_last(o_ls[0]), .busy(o_bsy[0])
    );

    sdf_stage_ctrl #(.FRAME_LEN(128), .DELAY(4), .TW_STEP(16), .TW_AW(6)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .mode(o_md[1]), .tw_addr(o_ad[1]), .tw_en(o_en[1]), .out_valid(o_ov[1]),
        .out_last(o_ls[1]), .busy(o_bsy[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_act[i] = 0; m_chf[i] = 0; m_pend[i] = 0; m_dl[i] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.rst.in_ready", i), 32'(o_rdy[i]), 1);
            check($sformatf("u%0d.rst.mode", i), 32'(o_md[i]), 0);
            check($sformatf("u%0d.rst.tw_addr", i), 32'(o_ad[i]), 0);
            check($sformatf("u%0d.rst.tw_en", i), 32'(o_en[i]), 0);
            check($sformatf("u%0d.rst.out_valid", i), 32'(o_ov[i]), 0);
            check($sformatf("u%0d.rst.out_last", i), 32'(o_ls[i]), 0);
            check($sformatf("u%0d.rst.busy", i), 32'(o_bsy[i]), 0);
        end
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        in_valid = v;
        #1;
        for (int i = 0; i < 2; i++) begin
            int e_rdy, e_md, e_en, e_ad, e_ov, e_ls, e_bsy;
            e_rdy = 1; e_md = 0; e_en = 0; e_ad = 0; e_ov = 0; e_ls = 0;
            e_bsy = (m_act[i] || m_pend[i] || m_dl[i] > 0) ? 1 : 0;
            if (m_dl[i] > 0 || (m_pend[i] && !v)) begin
                int d;
                d = (m_dl[i] > 0) ? DL[i] - m_dl[i] : 0;
                e_rdy = 0; e_md = 2; e_en = 1; e_ad = d * STP[i]; e_ov = 1;
                e_ls = (d == DL[i] - 1) ? 1 : 0;
            end else if (m_pend[i]) begin
                e_md = 2; e_en = 1; e_ad = 0; e_ov = 1;
            end else if (m_act[i]) begin
                bit fill;
                fill = !m_chf[i] && m_n[i] < DL[i];
                e_md = fill ? 0 : (((m_n[i] / DL[i]) % 2 == 1) ? 1 : 2);
                if (v && !fill) begin
                    e_ov = 1;
                    e_en = (e_md == 2) ? 1 : 0;
                    e_ad = e_en ? (m_n[i] % DL[i]) * STP[i] : 0;
                    e_ls = (m_chf[i] && m_n[i] == DL[i] - 1) ? 1 : 0;
                end
            end

            check($sformatf("u%0d.in_ready", i), 32'(o_rdy[i]), e_rdy);
            check($sformatf("u%0d.mode", i), 32'(o_md[i]), e_md);
            check($sformatf("u%0d.tw_en", i), 32'(o_en[i]), e_en);
            if (e_en == 1 || e_ov == 1 || e_bsy == 0)
                check($sformatf("u%0d.tw_addr", i), 32'(o_ad[i]), e_ad);
            check($sformatf("u%0d.out_valid", i), 32'(o_ov[i]), e_ov);
            check($sformatf("u%0d.out_last", i), 32'(o_ls[i]), e_ls);
            check($sformatf("u%0d.busy", i), 32'(o_bsy[i]), e_bsy);

            if (rec_on && rec_c < 160) begin
                rec_md[i][rec_c] = int'(o_md[i]);   rec_ad[i][rec_c] = int'(o_ad[i]);
                rec_en[i][rec_c] = int'(o_en[i]);   rec_ls[i][rec_c] = int'(o_ls[i]);
                rec_bsy[i][rec_c] = int'(o_bsy[i]); rec_rdy[i][rec_c] = int'(o_rdy[i]);
                rec_ov[i][rec_c] = int'(o_ov[i]);
            end

            if (m_dl[i] > 0) begin
                m_dl[i]--;
            end else if (m_pend[i] && !v) begin
                m_pend[i] = 0;
                m_dl[i] = DL[i] - 1;
            end else if (m_pend[i]) begin
                m_pend[i] = 0; m_act[i] = 1; m_chf[i] = 1; m_n[i] = 1;
            end else if (!m_act[i]) begin
                if (v) begin
                    m_act[i] = 1; m_chf[i] = 0; m_n[i] = 1;
                end
            end else if (v) begin
                if (m_n[i] == FL - 1) begin
                    m_n[i] = 0; m_act[i] = 0; m_pend[i] = 1;
                end else begin
                    m_n[i]++;
                end
            end
        end
        rec_c++;
    endtask

    task automatic run(input bit v, input int n);
        for (int k = 0; k < n; k++) step(v);
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // single frame, recorded for hand-computed pins
        rec_on = 1'b1; rec_c = 0;
        run(1, 128);
        run(0, 12);
        rec_on = 1'b0;

        check("pin.u0.c0.mode", rec_md[0][0], 0);
        check("pin.u0.c7.out_valid", rec_ov[0][7], 0);
        check("pin.u0.c8.mode", rec_md[0][8], 1);
        check("pin.u0.c16.tw_addr", rec_ad[0][16], 0);
        check("pin.u0.c17.tw_addr", rec_ad[0][17], 8);
        check("pin.u0.c23.tw_addr", rec_ad[0][23], 56);
        check("pin.u0.c23.mode", rec_md[0][23], 2);
        check("pin.u0.c127.mode", rec_md[0][127], 1);
        check("pin.u0.c128.in_ready", rec_rdy[0][128], 0);
        check("pin.u0.c128.tw_en", rec_en[0][128], 1);
        check("pin.u0.c134.out_last", rec_ls[0][134], 0);
        check("pin.u0.c135.out_last", rec_ls[0][135], 1);
        check("pin.u0.c135.tw_addr", rec_ad[0][135], 56);
        check("pin.u0.c136.busy", rec_bsy[0][136], 0);
        check("pin.u1.c3.mode", rec_md[1][3], 0);
        check("pin.u1.c4.mode", rec_md[1][4], 1);
        check("pin.u1.c9.tw_addr", rec_ad[1][9], 16);
        check("pin.u1.c11.tw_addr", rec_ad[1][11], 48);
        check("pin.u1.c131.out_last", rec_ls[1][131], 1);
        check("pin.u1.c132.busy", rec_bsy[1][132], 0);

        // back-to-back frames
        run(1, 256);
        run(0, 12);

        // gaps at pos 5 and pos 20
        run(1, 5);
        run(0, 3);
        run(1, 15);
        run(0, 3);
        run(1, 108);
        run(0, 12);

        // frame end, one empty cycle, then a held sample through the drain;
        // reach pos 40 of the next frame and reset mid-clock
        run(1, 128);
        run(0, 1);
        run(1, 47);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 128);
        run(0, 12);

        // randomized traffic
        for (int k = 0; k < 3000; k++) step($urandom_range(0, 99) < 85);
        run(0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
